// File: rtl/riscx_m_pkg.sv
// =============================================================================
// riscx_m_pkg : shared types and constants for the Type-M execution path
// Revision    : 1.0
// =============================================================================
`default_nettype none

package riscx_m_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [XLEN_DEFAULT-1:0] DIV_ZERO_Q = '1;
    localparam logic [XLEN_DEFAULT-1:0] INT_MIN    = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FAST  = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } div_ctrl_state_e;

    function automatic logic is_signed_op(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_req_ctrl_if.sv
// =============================================================================
// div_req_ctrl_if : valid/ready request and response channels to the divider
// Revision        : 1.0
// =============================================================================
`default_nettype none

interface div_req_ctrl_if #(
    parameter int XLEN = 32
) ();

    logic [XLEN-1:0] div_a_o;
    logic [XLEN-1:0] div_b_o;
    logic            div_signed_o;
    logic            div_in_valid_o;
    logic            div_in_ready_i;
    logic            div_out_valid_i;
    logic            div_out_ready_o;
    logic [XLEN-1:0] div_q_i;
    logic [XLEN-1:0] div_r_i;

    modport master (
        output div_a_o, div_b_o, div_signed_o, div_in_valid_o, div_out_ready_o,
        input  div_in_ready_i, div_out_valid_i, div_q_i, div_r_i
    );

    modport slave (
        input  div_a_o, div_b_o, div_signed_o, div_in_valid_o, div_out_ready_o,
        output div_in_ready_i, div_out_valid_i, div_q_i, div_r_i
    );

endinterface

`default_nettype wire

// File: rtl/div_special_case.sv
// =============================================================================
// div_special_case : RISC-V divide-by-zero / signed-overflow result resolver
// Revision         : 1.0
// =============================================================================
`default_nettype none

module div_special_case
    import riscx_m_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  div_op_e         op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            hit_o,
    output logic [XLEN-1:0] value_o
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic div_zero;
    logic overflow;

    always_comb begin
        div_zero = (rs2_i == '0);
        overflow = is_signed_op(op_i) && (rs1_i == MIN_VAL) && (rs2_i == '1);
        hit_o    = div_zero || overflow;
        value_o  = '0;
        // Divide-by-zero takes priority: it applies to every op
        if (div_zero) begin
            value_o = is_rem_op(op_i) ? rs1_i : '1;
        end else if (overflow) begin
            value_o = is_rem_op(op_i) ? '0 : MIN_VAL;
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_req_ctrl.sv
// =============================================================================
// div_req_ctrl : initiator-side controller for the handshaked iterative divider
// Revision     : 1.0
// =============================================================================
`default_nettype none

module div_req_ctrl
    import riscx_m_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid_i,
    input  logic [1:0]       op_code_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [TAG_W-1:0] rd_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             res_valid_o,
    output logic [XLEN-1:0]  res_o,
    output logic [TAG_W-1:0] res_rd_o,
    div_req_ctrl_if.master   div_bus
);

    div_ctrl_state_e  state_q;
    div_op_e          op_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic             signed_q;
    logic [TAG_W-1:0] rd_q;
    logic [XLEN-1:0]  fast_q;
    logic [XLEN-1:0]  res_q;
    logic [TAG_W-1:0] res_rd_q;
    logic             res_valid_q;

    logic             sc_hit;
    logic [XLEN-1:0]  sc_value;
    logic             fast_fire;
    logic             accept;

    div_special_case #(
        .XLEN (XLEN)
    ) u_special (
        .op_i    (div_op_e'(op_code_i)),
        .rs1_i   (rs1_i),
        .rs2_i   (rs2_i),
        .hit_o   (sc_hit),
        .value_o (sc_value)
    );

    // The result-strobe cycle of a divider op must not re-accept the op still held upstream
    assign accept    = (state_q == ST_IDLE) && op_valid_i && !flush_i && !res_valid_q;
    assign fast_fire = (state_q == ST_FAST) && !flush_i;

    assign res_valid_o = res_valid_q || fast_fire;
    assign res_o       = fast_fire ? fast_q : res_q;
    assign res_rd_o    = fast_fire ? rd_q   : res_rd_q;
    assign stall_o     = op_valid_i && !rst && !res_valid_o;

    assign div_bus.div_a_o         = a_q;
    assign div_bus.div_b_o         = b_q;
    assign div_bus.div_signed_o    = signed_q;
    assign div_bus.div_in_valid_o  = (state_q == ST_SEND);
    assign div_bus.div_out_ready_o = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_DIV;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            rd_q        <= '0;
            fast_q      <= '0;
            res_q       <= '0;
            res_rd_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= div_op_e'(op_code_i);
                        a_q      <= rs1_i;
                        b_q      <= rs2_i;
                        signed_q <= is_signed_op(div_op_e'(op_code_i));
                        rd_q     <= rd_i;
                        fast_q   <= sc_value;
                        state_q  <= sc_hit ? ST_FAST : ST_SEND;
                    end
                end
                ST_FAST: begin
                    if (!flush_i) begin
                        res_q    <= fast_q;
                        res_rd_q <= rd_q;
                    end
                    state_q <= ST_IDLE;
                end
                ST_SEND: begin
                    if (div_bus.div_in_ready_i) begin
                        state_q <= flush_i ? ST_DRAIN : ST_WAIT;
                    end else if (flush_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // A flush coinciding with the response already consumes it, so no drain
                    if (div_bus.div_out_valid_i) begin
                        if (!flush_i) begin
                            res_q       <= is_rem_op(op_q) ? div_bus.div_r_i : div_bus.div_q_i;
                            res_rd_q    <= rd_q;
                            res_valid_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end else if (flush_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (div_bus.div_out_valid_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_req_ctrl.sv
// =============================================================================
// tb_div_req_ctrl : directed and randomized bench for div_req_ctrl
// Revision        : 1.0
// =============================================================================
`default_nettype none

module tb_div_req_ctrl;
    import riscx_m_pkg::*;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        res_valid;
    logic [31:0] res;
    logic [4:0]  res_rd;

    int          checks;
    int          errors;
    logic [31:0] last_res;

    div_req_ctrl_if #(.XLEN(32)) dif ();

    div_req_ctrl #(
        .XLEN  (32),
        .TAG_W (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid_i  (op_valid),
        .op_code_i   (op_code),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .rd_i        (rd_in),
        .flush_i     (flush),
        .stall_o     (stall),
        .res_valid_o (res_valid),
        .res_o       (res),
        .res_rd_o    (res_rd),
        .div_bus     (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V M-extension semantics: 0=DIV 1=DIVU 2=REM 3=REMU
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return (op == 2'd2 || op == 2'd3) ? a : DIV_ZERO_Q;
        if ((op == 2'd0 || op == 2'd2) && a == INT_MIN && b == 32'hFFFF_FFFF)
            return (op == 2'd2) ? 32'd0 : INT_MIN;
        case (op)
            2'd0:    return $unsigned(sa / sb);
            2'd1:    return a / b;
            2'd2:    return $unsigned(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic logic ref_is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || ((op == 2'd0 || op == 2'd2) && a == INT_MIN && b == 32'hFFFF_FFFF);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stall"},     32'(stall), 0);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
        check({tag, "_res"},       res, 0);
        check({tag, "_res_rd"},    32'(res_rd), 0);
        check({tag, "_in_valid"},  32'(dif.div_in_valid_o), 0);
        check({tag, "_out_ready"}, 32'(dif.div_out_ready_o), 0);
        check({tag, "_div_a"},     dif.div_a_o, 0);
        check({tag, "_div_b"},     dif.div_b_o, 0);
        check({tag, "_signed"},    32'(dif.div_signed_o), 0);
    endtask

    task automatic present(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        op_valid = 1'b1;
        op_code  = op;
        rs1      = a;
        rs2      = b;
        rd_in    = rd;
    endtask

    // One complete op, starting in IDLE; divider stalls rdy_wait cycles on input, out_wait on output
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int rdy_wait, input int out_wait);
        logic [31:0] exp;
        logic        sg;
        exp = ref_result(op, a, b);
        sg  = (op == 2'd0 || op == 2'd2);
        present(op, a, b, rd);
        flush = 1'b0;
        @(negedge clk);
        check("accept_stall", 32'(stall), 1);
        check("accept_no_req", 32'(dif.div_in_valid_o), 0);
        check("accept_no_res", 32'(res_valid), 0);
        tick();
        if (ref_is_fast(op, a, b)) begin
            @(negedge clk);
            check("fast_valid", 32'(res_valid), 1);
            check("fast_res", res, exp);
            check("fast_rd", 32'(res_rd), 32'(rd));
            check("fast_no_req", 32'(dif.div_in_valid_o), 0);
            check("fast_stall", 32'(stall), 0);
            tick();
        end else begin
            for (int k = 0; k <= rdy_wait; k++) begin
                dif.div_in_ready_i = (k == rdy_wait);
                @(negedge clk);
                check("send_valid", 32'(dif.div_in_valid_o), 1);
                check("send_a", dif.div_a_o, a);
                check("send_b", dif.div_b_o, b);
                check("send_signed", 32'(dif.div_signed_o), 32'(sg));
                check("send_stall", 32'(stall), 1);
                check("send_out_ready", 32'(dif.div_out_ready_o), 0);
                check("send_no_res", 32'(res_valid), 0);
                tick();
            end
            dif.div_in_ready_i = 1'b0;
            for (int j = 0; j <= out_wait; j++) begin
                dif.div_out_valid_i = (j == out_wait);
                if (j == out_wait) begin
                    dif.div_q_i = ref_result(sg ? 2'd0 : 2'd1, a, b);
                    dif.div_r_i = ref_result(sg ? 2'd2 : 2'd3, a, b);
                end else begin
                    dif.div_q_i = $urandom;
                    dif.div_r_i = $urandom;
                end
                @(negedge clk);
                check("wait_out_ready", 32'(dif.div_out_ready_o), 1);
                check("wait_no_req", 32'(dif.div_in_valid_o), 0);
                check("wait_no_res", 32'(res_valid), 0);
                check("wait_stall", 32'(stall), 1);
                tick();
            end
            dif.div_out_valid_i = 1'b0;
            dif.div_q_i = $urandom;
            dif.div_r_i = $urandom;
            @(negedge clk);
            check("div_res_valid", 32'(res_valid), 1);
            check("div_res", res, exp);
            check("div_rd", 32'(res_rd), 32'(rd));
            check("div_res_stall", 32'(stall), 0);
            check("div_res_out_ready", 32'(dif.div_out_ready_o), 0);
            tick();
        end
        last_res = exp;
        op_valid = 1'b0;
        rs1      = $urandom;
        rs2      = $urandom;
        @(negedge clk);
        check("idle_no_res", 32'(res_valid), 0);
        check("idle_hold", res, last_res);
        check("idle_no_req", 32'(dif.div_in_valid_o), 0);
        tick();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        checks   = 0;
        errors   = 0;
        last_res = 32'd0;
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = 2'd0;
        rs1      = 32'd0;
        rs2      = 32'd0;
        rd_in    = 5'd0;
        flush    = 1'b0;
        dif.div_in_ready_i  = 1'b0;
        dif.div_out_valid_i = 1'b0;
        dif.div_q_i = 32'd0;
        dif.div_r_i = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd5, 1, 2);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 0);
        do_op(2'd1, 32'd100, 32'd0, 5'd7, 0, 0);
        do_op(2'd3, 32'd100, 32'd0, 5'd8, 0, 0);
        do_op(2'd0, INT_MIN, 32'hFFFF_FFFF, 5'd9, 0, 0);
        do_op(2'd2, INT_MIN, 32'hFFFF_FFFF, 5'd10, 0, 0);
        do_op(2'd1, 32'd1000, 32'd7, 5'd11, 5, 1);

        // flush in WAIT: response is drained, next op accepted right after
        present(2'd1, 32'd50, 32'd7, 5'd3);
        @(negedge clk);
        tick();
        dif.div_in_ready_i = 1'b1;
        @(negedge clk);
        check("fw_send", 32'(dif.div_in_valid_o), 1);
        tick();
        dif.div_in_ready_i = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("fw_out_ready", 32'(dif.div_out_ready_o), 1);
        check("fw_no_res", 32'(res_valid), 0);
        tick();
        flush = 1'b0;
        present(2'd1, 32'd20, 32'd4, 5'd12);
        @(negedge clk);
        check("drain_out_ready", 32'(dif.div_out_ready_o), 1);
        check("drain_no_req", 32'(dif.div_in_valid_o), 0);
        check("drain_stall", 32'(stall), 1);
        tick();
        dif.div_out_valid_i = 1'b1;
        dif.div_q_i = 32'd7;
        dif.div_r_i = 32'd1;
        @(negedge clk);
        check("drain_no_res", 32'(res_valid), 0);
        check("drain_stall2", 32'(stall), 1);
        check("drain_hold", res, last_res);
        tick();
        dif.div_out_valid_i = 1'b0;
        do_op(2'd1, 32'd20, 32'd4, 5'd12, 0, 1);

        // flush in FAST: no strobe, result register untouched
        present(2'd1, 32'd1, 32'd0, 5'd13);
        @(negedge clk);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("ff_no_res", 32'(res_valid), 0);
        check("ff_hold", res, last_res);
        tick();
        flush    = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("ff_idle_no_res", 32'(res_valid), 0);
        check("ff_idle_no_req", 32'(dif.div_in_valid_o), 0);
        tick();

        // flush in SEND before the handshake
        present(2'd0, 32'd20, 32'd3, 5'd14);
        @(negedge clk);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("fs_send", 32'(dif.div_in_valid_o), 1);
        tick();
        flush    = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("fs_dropped", 32'(dif.div_in_valid_o), 0);
        check("fs_out_ready", 32'(dif.div_out_ready_o), 0);
        tick();

        // asynchronous reset while in WAIT
        present(2'd1, 32'd77, 32'd5, 5'd9);
        @(negedge clk);
        tick();
        dif.div_in_ready_i = 1'b1;
        @(negedge clk);
        tick();
        dif.div_in_ready_i = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("rw_out_ready", 32'(dif.div_out_ready_o), 1);
        #2 rst = 1'b1;
        #1 check_zero("rst_wait");
        tick();
        rst = 1'b0;
        last_res = 32'd0;
        @(negedge clk);
        check_zero("rst_after");
        tick();
        do_op(2'd1, 32'd9, 32'd3, 5'd15, 0, 0);

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 5));
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) begin
                b = 32'd0;
            end else if (sel == 1) begin
                a = INT_MIN;
                b = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                b = $urandom_range(1, 16);
            end
            do_op(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_req_ctrl.md
# div_req_ctrl

Initiator-side controller for the handshaked iterative divider in the Type-M execution path. It accepts DIV/DIVU/REM/REMU operations from the execute stage and resolves the RISC-V corner cases (divide-by-zero, signed overflow) locally without engaging the divider. All other operations are issued over the divider's valid/ready input handshake, and the divider's output handshake is consumed. The result is returned with a destination tag, and the pipeline is stalled while an operation is in flight.

## Interface
- XLEN, 32, operand/result width
- TAG_W, 5, destination register tag width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- op_valid_i  in  1  execute stage presents a divide op
- op_code_i  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- rs1_i, rs2_i  in  XLEN  dividend, divisor
- rd_i  in  TAG_W  destination tag
- flush_i  in  1  kill the current op (branch/trap)
- stall_o  out  1  execute stage must hold
- res_valid_o  out  1  one-cycle result strobe
- res_o  out  XLEN  quotient or remainder
- res_rd_o  out  TAG_W  tag of res_o
- div_a_o, div_b_o  out  XLEN  divider operands
- div_signed_o  out  1  drives the divider's signal_division
- div_in_valid_o  out  1  request to divider
- div_in_ready_i  in  1  divider can accept
- div_out_valid_i  in  1  divider result valid
- div_out_ready_o  out  1  controller accepts result
- div_q_i, div_r_i  in  XLEN  divider quotient/remainder; valid only while div_out_valid_i && div_out_ready_o

## Operation
- Registered state enum: IDLE, FAST, SEND, WAIT, DRAIN.
- **IDLE**: op_valid_i && !flush_i latches rs1, rs2, rd, and op_code.
  - Special case detected → FAST.
  - Otherwise → SEND.
- Divide-by-zero (rs2==0): quotient = all ones; remainder = rs1. Applies to all four ops.
- Signed overflow (DIV/REM, rs1==0x80000000, rs2==0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- **FAST**: drive res_valid_o with the precomputed value → IDLE. The divider is never requested.
- **SEND**:
  - div_in_valid_o=1.
  - div_a_o, div_b_o, and div_signed_o (1 for DIV/REM) come from registers and stay stable until handshake.
  - div_in_valid_o && div_in_ready_i → WAIT.
- **WAIT**:
  - div_out_ready_o=1.
  - On div_out_valid_i, capture div_q_i (DIV/DIVU) or div_r_i (REM/REMU) into res_o in the same cycle.
  - Pulse res_valid_o next cycle → IDLE.
- **flush_i** behaviour by state:
  - In FAST: → IDLE, no res_valid_o.
  - In SEND before handshake: drop div_in_valid_o → IDLE.
  - In SEND on the handshake cycle, or in WAIT: → DRAIN. The divider cannot abort.
- **DRAIN**: div_out_ready_o=1; on div_out_valid_i discard the result → IDLE. No res_valid_o.
- flush_i in IDLE blocks acceptance that cycle.
- stall_o = op_valid_i && (state!=IDLE || not-yet-accepted). It is asserted from the accept cycle until the cycle res_valid_o is high, and during DRAIN.
- The result register holds its value between strobes.
- Reset values: all outputs 0, state IDLE, internal registers 0.
- reset mid-operation returns to IDLE immediately. The divider is reset by the same signal, so no drain is needed.

## Timing
- Fast path: accept at cycle N, res_valid_o at N+1 (2-cycle op).
- Divider path: accept at N, div_in_valid_o from N+1.
  - Handshake at N+1+k (k = divider ready wait).
  - Result captured at the div_out_valid_i cycle M; res_valid_o at M+1.
- div_in_valid_o, once asserted, stays high until handshake unless flush_i. Operands must not change while it is high.
- div_out_ready_o is 1 only in WAIT and DRAIN, never in IDLE/SEND/FAST.
- At most one op is outstanding; no new acceptance before return to IDLE. This gives a one-cycle bubble between back-to-back ops.
- res_valid_o is exactly one cycle per completed op and is never asserted in DRAIN.

## Structure
- Shared package riscx_m_pkg:
  - div_op_e (DIV, DIVU, REM, REMU)
  - div_ctrl_state_e
  - XLEN default
  - constants DIV_ZERO_Q (all ones) and INT_MIN (0x80000000)
- One combinational sub-module, div_special_case, maps (op, rs1, rs2) to {hit, value}. It is reusable by a future fast divider.

## Test plan
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 → one div handshake, div_signed_o=1, res_o=0xFFFFFFFD (-3), rd echoed. Under REM the same operands → res_o=0xFFFFFFFF (-1).
- DIVU 100/0 → res_valid_o one cycle after accept with 0xFFFFFFFF; REMU 100/0 → 100; div_in_valid_o never asserted.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0; both via FAST.
- div_in_ready_i held low 5 cycles → div_in_valid_o, div_a_o, and div_b_o stable throughout, stall_o high; one handshake on release.
- flush_i in WAIT → DRAIN; the divider result arrives and is consumed with no res_valid_o; a following op is accepted the cycle after return to IDLE.
- reset asserted in WAIT → all outputs 0 asynchronously, state IDLE; after release, DIVU 9/3 → res_o=3.
